// File: rtl/apb_sin_pkg.sv
// Shared constants, engine states and the quadrant fold for the APB sine generator.
package apb_sin_pkg;

  localparam logic [3:0] OFS_PHASE = 4'h0;
  localparam logic [3:0] OFS_SIN   = 4'h4;
  localparam logic [3:0] OFS_STEP  = 4'h8;
  localparam logic [3:0] OFS_CTRL  = 4'hC;

  localparam int CTRL_AUTO_BIT = 0;
  localparam int CTRL_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    ENG_IDLE   = 2'd0,
    ENG_LOOKUP = 2'd1,
    ENG_APPLY  = 2'd2
  } eng_state_e;

  typedef struct packed {
    logic        neg;
    logic [30:0] idx;
  } fold_t;

  // Odd quadrants mirror the quarter table, the lower half-plane negates it.
  function automatic fold_t quad_fold(input logic [31:0] k, input int pb);
    fold_t       f;
    logic [31:0] qn;
    logic [31:0] r;
    logic [1:0]  q;
    qn    = 32'd1 << (pb - 2);
    r     = k & (qn - 32'd1);
    q     = 2'(k >> (pb - 2));
    f.neg = q[1];
    f.idx = q[0] ? 31'(qn - r) : 31'(r);
    return f;
  endfunction

endpackage

// File: rtl/sin_quarter_rom.sv
// Quarter-wave sine table S(0..N/4), magnitudes only; one-cycle registered read.
// Entries are round((2^(OUT_W-1)-1) * sin(2*pi*i/N)), evaluated at elaboration.
module sin_quarter_rom #(
  parameter int PHASE_BITS = 3,
  parameter int OUT_W      = 16
) (
  input  logic                  clk,
  input  logic [PHASE_BITS-1:0] addr_i,
  output logic [OUT_W-1:0]      data_o
);

  localparam int  QN  = 1 << (PHASE_BITS - 2);
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = real'((64'd1 << (OUT_W - 1)) - 64'd1);

  logic [OUT_W-1:0] rom [0:QN];
  logic [OUT_W-1:0] data_q;

  for (genvar i = 0; i <= QN; i++) begin : g_rom
    localparam real V = AMP * $sin(2.0 * PI * i / (4.0 * QN));
    assign rom[i] = OUT_W'($rtoi(V + 0.5));
  end

  always_ff @(posedge clk) begin
    data_q <= rom[addr_i[PHASE_BITS-2:0]];
  end

  assign data_o = data_q;

  logic unused_addr;
  assign unused_addr = addr_i[PHASE_BITS-1];

endmodule

// File: rtl/apb_sin_gen.sv
// APB sine generator: per-channel PHASE/SIN/STEP/CTRL, one shared quarter-ROM engine (3 cycles/channel).
// Every access takes one wait state; a SIN read of a busy channel stalls PREADY until its result lands.
module apb_sin_gen
  import apb_sin_pkg::*;
#(
  parameter int PHASE_BITS = 3,
  parameter int OUT_W      = 16,
  parameter int CHANNELS   = 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PHASE_BITS-1:0] phase_q [CHANNELS];
  logic [PHASE_BITS-1:0] phase_d [CHANNELS];
  logic [PHASE_BITS-1:0] step_q  [CHANNELS];
  logic [PHASE_BITS-1:0] step_d  [CHANNELS];
  logic [OUT_W-1:0]      sin_q   [CHANNELS];
  logic [OUT_W-1:0]      sin_d   [CHANNELS];
  logic [CHANNELS-1:0]   auto_q, auto_d;
  logic [CHANNELS-1:0]   pending_q, pending_d;
  logic [CHANNELS-1:0]   set_pend, pend_clr, busy;

  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  eng_state_e            state_q, state_d;
  logic [CW-1:0]         cur_q, cur_d;
  logic                  neg_q, neg_d;
  logic [PHASE_BITS-1:0] idx_q, idx_d;
  logic [OUT_W-1:0]      rom_data;
  logic [CW-1:0]         pick;
  fold_t                 fold_w;

  // Address decode
  logic [CW-1:0] ch;
  logic [3:0]    ofs;
  logic          bad_ch, bad_align, is_sin, err, access, stall;
  logic [31:0]   rdata;

  assign ch        = PADDR[4 +: CW];
  assign ofs       = PADDR[3:0];
  assign bad_ch    = PADDR[31:4] >= 28'(CHANNELS);
  assign bad_align = ofs[1:0] != 2'b00;
  assign is_sin    = ofs == OFS_SIN;
  assign err       = bad_ch | bad_align | (PWRITE & is_sin);
  assign access    = PSEL & PENABLE;
  assign stall     = !PWRITE & is_sin & !bad_ch & !bad_align & busy[ch];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = pending_q[i] | ((state_q != ENG_IDLE) && (cur_q == CW'(i)));
    end
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_PHASE: rdata = 32'(phase_q[ch]);
      OFS_SIN:   rdata = 32'($signed(sin_q[ch]));
      OFS_STEP:  rdata = 32'(step_q[ch]);
      OFS_CTRL: begin
        rdata[CTRL_AUTO_BIT] = auto_q[ch];
        rdata[CTRL_BUSY_BIT] = busy[ch];
      end
      default:   rdata = '0;
    endcase
  end

  // Bus side: respond at the end of the access cycle, commit side effects at completion.
  always_comb begin
    phase_d   = phase_q;
    step_d    = step_q;
    auto_d    = auto_q;
    set_pend  = '0;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    if (!pready_q) begin
      if (access && !stall) begin
        pready_d  = 1'b1;
        pslverr_d = err;
        if (!PWRITE && !err) prdata_d = rdata;
      end
    end else if (access && !err) begin
      if (PWRITE) begin
        case (ofs)
          OFS_PHASE: begin
            phase_d[ch]  = PWDATA[PHASE_BITS-1:0];
            set_pend[ch] = 1'b1;
          end
          OFS_STEP: step_d[ch] = PWDATA[PHASE_BITS-1:0];
          OFS_CTRL: auto_d[ch] = PWDATA[CTRL_AUTO_BIT];
          default:  ;
        endcase
      end else if (is_sin && auto_q[ch]) begin
        phase_d[ch]  = phase_q[ch] + step_q[ch];
        set_pend[ch] = 1'b1;
      end
    end
  end

  always_comb begin
    pick = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending_q[i]) pick = CW'(i);
    end
  end

  assign fold_w = quad_fold(32'(phase_q[pick]), PHASE_BITS);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    neg_d    = neg_q;
    idx_d    = idx_q;
    sin_d    = sin_q;
    pend_clr = '0;
    case (state_q)
      ENG_IDLE: begin
        if (|pending_q) begin
          cur_d          = pick;
          neg_d          = fold_w.neg;
          idx_d          = fold_w.idx[PHASE_BITS-1:0];
          pend_clr[pick] = 1'b1;
          state_d        = ENG_LOOKUP;
        end
      end
      ENG_LOOKUP: state_d = ENG_APPLY;
      ENG_APPLY: begin
        sin_d[cur_q] = neg_q ? (OUT_W'(0) - rom_data) : rom_data;
        state_d      = ENG_IDLE;
      end
      default: state_d = ENG_IDLE;
    endcase
  end

  // A new request landing as the engine takes the old one must survive.
  assign pending_d = (pending_q & ~pend_clr) | set_pend;

  sin_quarter_rom #(
    .PHASE_BITS(PHASE_BITS),
    .OUT_W     (OUT_W)
  ) u_rom (
    .clk   (PCLK),
    .addr_i(idx_q),
    .data_o(rom_data)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= '0;
        step_q[i]  <= '0;
        sin_q[i]   <= '0;
      end
      auto_q    <= '0;
      pending_q <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      state_q   <= ENG_IDLE;
      cur_q     <= '0;
      neg_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      step_q    <= step_d;
      sin_q     <= sin_d;
      auto_q    <= auto_d;
      pending_q <= pending_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      state_q   <= state_d;
      cur_q     <= cur_d;
      neg_q     <= neg_d;
      idx_q     <= idx_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

  logic unused_bits;
  assign unused_bits = ^{fold_w.idx[30:PHASE_BITS], PWDATA[31:PHASE_BITS]};

endmodule

// File: tb/tb_apb_sin_gen.sv
// Randomized APB bench for apb_sin_gen, checked against a real-arithmetic sine model.
module tb_apb_sin_gen;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_sin_gen #(.PHASE_BITS(3), .OUT_W(16), .CHANNELS(2)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: signed Q1.15 of sin(2*pi*k/8), rounded half away from zero.
  function automatic logic [31:0] exp_sin(input int k);
    real v;
    int  r;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k % 8) / 8.0);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return 32'(r);
  endfunction

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int waits);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    while (!PREADY && waits < 100) begin
      @(posedge PCLK); #1;
      waits++;
    end
    if (!PREADY) check("pready_timeout", {31'b0, PREADY}, 32'd1);
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("pready_drop", {31'b0, PREADY}, 32'd0);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] r;
    logic        e;
    int          w;
    xfer(1'b1, addr, d, r, e, w);
    check({tag, "_slverr"}, {31'b0, e}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp, output int w);
    logic [31:0] r;
    logic        e;
    xfer(1'b0, addr, 32'd0, r, e, w);
    check({tag, "_slverr"}, {31'b0, e}, 32'd0);
    check(tag, r, exp);
  endtask

  task automatic wait_not_busy(input logic [31:0] ctrl_addr);
    logic [31:0] r;
    logic        e;
    int          w;
    int          n;
    n = 0;
    do begin
      xfer(1'b0, ctrl_addr, 32'd0, r, e, w);
      n++;
    end while (r[1] && n < 20);
    if (n >= 20) check("busy_timeout", {31'b0, r[1]}, 32'd0);
  endtask

  int          m_phase;
  int          m_step;
  int          w;
  int          k;
  int          fixed_k [3] = '{6, 5, 4};
  logic [31:0] r;
  logic        e;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    for (int c = 0; c < 2; c++) begin
      for (int o = 0; o < 16; o += 4) rd("rst_reg", 32'(c * 16 + o), 32'd0, w);
    end

    wr("ph1", 32'h0, 32'd1);
    repeat (4) @(posedge PCLK);
    rd("sin_k1", 32'h4, 32'h0000_5A82, w);
    check("sin_k1_waits", 32'(w), 32'd1);

    wr("ph2", 32'h0, 32'd2);
    rd("sin_k2_stalled", 32'h4, 32'h0000_7FFF, w);
    check("sin_k2_was_stalled", {31'b0, w > 1}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      k = (i < 3) ? fixed_k[i] : int'($urandom_range(0, 7));
      wr("ph_rand", 32'h0, 32'(k) | ($urandom & 32'hFFFF_FFF8));
      rd("sin_rand", 32'h4, exp_sin(k), w);
      rd("phase_rb", 32'h0, 32'(k), w);
    end

    wr("auto_on", 32'hC, 32'd1);
    wr("step3", 32'h8, 32'd3);
    wr("ph0", 32'h0, 32'd0);
    m_phase = 0;
    for (int i = 0; i < 8; i++) begin
      rd("auto_sin", 32'h4, exp_sin(m_phase), w);
      m_phase = (m_phase + 3) % 8;
    end
    rd("auto_wrap_phase", 32'h0, 32'(m_phase), w);

    m_step  = int'($urandom_range(0, 7));
    m_phase = int'($urandom_range(0, 7));
    wr("step_rand", 32'h8, 32'(m_step));
    wr("ph_rand_auto", 32'h0, 32'(m_phase));
    rd("step_rb", 32'h8, 32'(m_step), w);
    for (int i = 0; i < 6; i++) begin
      rd("auto_rand_sin", 32'h4, exp_sin(m_phase), w);
      m_phase = (m_phase + m_step) % 8;
    end
    wr("auto_off", 32'hC, 32'd0);
    rd("noauto_sin_a", 32'h4, exp_sin(m_phase), w);
    rd("noauto_sin_b", 32'h4, exp_sin(m_phase), w);
    rd("noauto_phase", 32'h0, 32'(m_phase), w);

    wr("two_ph0", 32'h00, 32'd2);
    wr("two_ph1", 32'h10, 32'd6);
    rd("ctrl1_busy", 32'h1C, 32'h0000_0002, w);
    wait_not_busy(32'h0C);
    wait_not_busy(32'h1C);
    rd("ctrl0_idle", 32'h0C, 32'd0, w);
    rd("ctrl1_idle", 32'h1C, 32'd0, w);
    rd("two_sin0", 32'h04, 32'h0000_7FFF, w);
    rd("two_sin1", 32'h14, 32'hFFFF_8001, w);

    rd("pre_err_phase", 32'h00, 32'd2, w);
    xfer(1'b1, 32'h04, 32'h1234, r, e, w);
    check("err_wr_sin", {31'b0, e}, 32'd1);
    check("prdata_held_on_write", PRDATA, 32'd2);
    xfer(1'b0, 32'h20, 32'd0, r, e, w);
    check("err_rd_ch2", {31'b0, e}, 32'd1);
    xfer(1'b0, 32'h02, 32'd0, r, e, w);
    check("err_rd_unaligned", {31'b0, e}, 32'd1);
    xfer(1'b1, 32'h01, 32'd5, r, e, w);
    check("err_wr_unaligned", {31'b0, e}, 32'd1);
    xfer(1'b1, 32'h30, 32'd5, r, e, w);
    check("err_wr_ch3", {31'b0, e}, 32'd1);
    rd("post_err_sin0", 32'h04, 32'h0000_7FFF, w);
    rd("post_err_phase0", 32'h00, 32'd2, w);
    rd("post_err_ctrl0", 32'h0C, 32'd0, w);
    wr("ctrl1_busy_wr", 32'h1C, 32'd3);
    rd("ctrl1_busy_ro", 32'h1C, 32'd1, w);
    wr("ctrl1_clear", 32'h1C, 32'd0);

    wr("pre_rst_step", 32'h08, 32'd5);
    wr("pre_rst_phase", 32'h00, 32'd3);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    check("mid_rst_pready", {31'b0, PREADY}, 32'd0);
    check("mid_rst_prdata", PRDATA, 32'd0);
    for (int c = 0; c < 2; c++) begin
      for (int o = 0; o < 16; o += 4) rd("mid_rst_reg", 32'(c * 16 + o), 32'd0, w);
    end
    wr("post_rst_ph", 32'h0, 32'd1);
    rd("post_rst_sin", 32'h4, 32'h0000_5A82, w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_sin_gen.md
# apb_sin_gen

APB slave providing CHANNELS independent sine channels. Each channel holds a phase index k (angle 2πk/N, N = 2^PHASE_BITS) and returns sin as a signed fixed-point word. One shared quarter-wave lookup engine serves all channels, using symmetry. Optional per-channel auto-increment lets software step through a waveform by repeatedly reading one register.

## Interface
- PHASE_BITS, 3: phase index width, N = 2^PHASE_BITS steps per period; must be ≥ 2.
- OUT_W, 16: result width, signed Q1.(OUT_W-1); must be ≤ 32.
- CHANNELS, 2: number of channels, 1..8.
- PCLK  in  1  clock; everything is on the rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- PSEL  in  1  peripheral select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error, valid while PREADY = 1.

## Operation
- Address map: channel c base = c·0x10; PADDR[31:4] selects the channel, PADDR[3:0] the register.
  - 0x0 PHASE: RW, PHASE_BITS bits, upper bits read 0. A write schedules a compute.
  - 0x4 SIN: RO. Result is sign-extended to 32 bits.
  - 0x8 STEP: RW, PHASE_BITS bits. A write does not trigger a compute.
  - 0xC CTRL: bit0 AUTO (RW); bit1 BUSY (RO, write ignored).
- Error responses set PSLVERR = 1 and leave all state unchanged:
  - channel ≥ CHANNELS;
  - unaligned address;
  - write to SIN.
- Result value:
  - S(k) = round((2^(OUT_W-1) − 1) · sin(2πk/N)); +1 maps to 2^(OUT_W-1) − 1 (no overflow).
  - Quarter ROM holds S(0..N/4).
  - Quadrant q = k[PB-1:PB-2], r = k[PB-3:0] (PB = PHASE_BITS).
  - q0: rom[r]; q1: rom[N/4 − r]; q2: −rom[r]; q3: −rom[N/4 − r].
- Engine FSM: IDLE → LOOKUP → APPLY → IDLE.
  - IDLE: picks the lowest-index channel with pending = 1, clears its pending bit, latches its phase.
  - LOOKUP: registered ROM read.
  - APPLY: applies sign, writes SIN[c].
  - BUSY[c] = pending[c] OR (engine currently serving c).
- AUTO = 1: a completed, error-free SIN read then does phase ← (phase + STEP) mod N and sets pending. The read returns the old value.
- A PHASE write while the channel is BUSY sets pending again. The in-flight result is still written, then recomputed with the new phase. The newest phase always wins.
- If pending is set and the engine clears it in the same cycle, set wins.

## Timing
- All outputs are registered.
- Access phase starts in cycle A (PSEL = PENABLE = 1).
  - Normal case: PREADY = 1 in cycle A+1 (one wait state). The transfer completes at the end of A+1.
  - PREADY returns to 0 in A+2 even if PSEL stays high.
- A SIN read of a BUSY channel holds PREADY low until BUSY falls. PREADY rises the cycle after, with the fresh value.
- Writes take effect at the completion edge.
- Compute latency: PHASE write completing at edge E gives pending at E, then IDLE, LOOKUP, APPLY. SIN is valid, BUSY = 0, 3 cycles after E when the engine is free. Each extra queued channel adds 3 cycles.
- PRDATA is updated only on read completion and is held otherwise. PSLVERR is 0 whenever PREADY = 0.
- Reset, including mid-transfer or mid-compute:
  - PRDATA, PREADY, PSLVERR = 0;
  - all PHASE, STEP, CTRL, SIN = 0; pending = 0;
  - FSM goes to IDLE; any in-flight transfer is abandoned with no PREADY.

## Structure
- Package apb_sin_pkg holds:
  - register offset constants (OFS_PHASE, OFS_SIN, OFS_STEP, OFS_CTRL);
  - CTRL bit positions;
  - engine state enum;
  - quadrant-fold function.
- Sub-module sin_quarter_rom:
  - parameters PHASE_BITS, OUT_W; N/4 + 1 entries computed at elaboration;
  - one-cycle registered read.
- Top contains the APB FSM, register file, pending/priority logic and the engine.

## Test plan
All at defaults (N = 8, OUT_W = 16).
- Write PHASE0 = 1, then read SIN0 → 0x00005A82 (23170).
- Read SIN0 immediately after writing PHASE0 = 2 → PREADY is stalled until BUSY falls, then returns 0x00007FFF.
- PHASE0 = 6 → SIN0 reads 0xFFFF8001. PHASE0 = 5 → 0xFFFFA57E. PHASE0 = 4 → 0x00000000.
- AUTO0 = 1, STEP0 = 3, PHASE0 = 0; eight SIN0 reads → phases 0, 3, 6, 1, 4, 7, 2, 5 with values 0, 23170, −32767, 23170, 0, −23170, 32767, −23170. Wrap occurs correctly.
- Write PHASE0 = 2 and PHASE1 = 6 back-to-back → channel 0 is served first. Both BUSY bits eventually clear. SIN1 = 0xFFFF8001.
- Write to SIN0, read address 0x20, read address 0x02 → PSLVERR = 1 each time, no state change.
- Assert PRESET during the LOOKUP state → all registers read 0 afterwards, and a new transfer works normally.
